// File: rtl/cache_line_mover.sv
// Refill/writeback engine for one cache way: optionally writes the victim line
// back to memory word by word, then fetches the new line into the way and installs its tag.
module cache_line_mover #(
  parameter int unsigned LINES           = 2,
  parameter int unsigned WORDS_PER_BLOCK = 32,
  parameter int unsigned TAG_LENGTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  req_wb,
  input  logic [31:0]           req_wb_addr,
  input  logic [31:0]           req_fill_addr,
  input  logic [TAG_LENGTH-1:0] req_tag,
  output logic                  busy,
  output logic                  done,
  output logic                  way_en,
  output logic [31:0]           way_a,
  output logic [31:0]           way_d,
  output logic                  way_we,
  input  logic [31:0]           way_spo,
  output logic                  way_tag_we,
  output logic [TAG_LENGTH-1:0] way_tag_in,
  output logic [31:0]           mem_a,
  output logic [31:0]           mem_d,
  output logic                  mem_we,
  output logic                  mem_rd,
  input  logic [31:0]           mem_spo,
  input  logic                  mem_ready
);

  localparam int unsigned OW         = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned CW         = (OW > 0) ? OW : 1;
  localparam int unsigned LINE_BYTES = WORDS_PER_BLOCK * 4;
  localparam logic [31:0] LINE_MASK  = 32'(LINE_BYTES - 1);
  localparam logic [31:0] WAY_MASK   = 32'(LINES * LINE_BYTES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WORDS_PER_BLOCK - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WB_ADDR, S_WB_LAT, S_WB_REQ, S_FILL_REQ, S_FILL_WR, S_TAG, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [31:0]     wb_base, wb_base_nxt;
  logic [31:0]     fill_base, fill_base_nxt;
  logic            cnt_last;
  logic            accept;
  logic [31:0]     wb_word_nxt, fill_word_nxt;

  logic                  busy_nxt, done_nxt, way_en_nxt, way_we_nxt, way_tag_we_nxt;
  logic                  mem_we_nxt, mem_rd_nxt;
  logic [31:0]           way_a_nxt, way_d_nxt, mem_a_nxt, mem_d_nxt;
  logic [TAG_LENGTH-1:0] way_tag_in_nxt;

  assign cnt_last = (cnt == CNT_LAST);
  assign accept   = (state == S_IDLE) && req;

  // State, word counter and latched line bases
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wb_base   <= '0;
      fill_base <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      wb_base   <= wb_base_nxt;
      fill_base <= fill_base_nxt;
    end
  end

  // Next state; the counter advances only as a word completes
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    wb_base_nxt   = wb_base;
    fill_base_nxt = fill_base;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt     = req_wb ? S_WB_ADDR : S_FILL_REQ;
          cnt_nxt       = '0;
          wb_base_nxt   = req_wb_addr & ~LINE_MASK;
          fill_base_nxt = req_fill_addr & ~LINE_MASK;
        end
      end
      S_WB_ADDR: state_nxt = S_WB_LAT;
      S_WB_LAT:  state_nxt = S_WB_REQ;
      S_WB_REQ: begin
        if (mem_ready) begin
          if (cnt_last) begin
            cnt_nxt   = '0;
            state_nxt = S_FILL_REQ;
          end else begin
            cnt_nxt   = cnt + CW'(1);
            state_nxt = S_WB_ADDR;
          end
        end
      end
      S_FILL_REQ: begin
        if (mem_ready) state_nxt = S_FILL_WR;
      end
      S_FILL_WR: begin
        if (cnt_last) begin
          cnt_nxt   = '0;
          state_nxt = S_TAG;
        end else begin
          cnt_nxt   = cnt + CW'(1);
          state_nxt = S_FILL_REQ;
        end
      end
      S_TAG:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign wb_word_nxt   = wb_base_nxt | (32'(cnt_nxt) << 2);
  assign fill_word_nxt = fill_base_nxt | (32'(cnt_nxt) << 2);

  // Output decode from the upcoming state so every output leaves a flop
  always_comb begin
    busy_nxt       = 1'b0;
    done_nxt       = 1'b0;
    way_en_nxt     = 1'b0;
    way_we_nxt     = 1'b0;
    way_tag_we_nxt = 1'b0;
    mem_we_nxt     = 1'b0;
    mem_rd_nxt     = 1'b0;
    way_a_nxt      = way_a;
    mem_a_nxt      = mem_a;
    mem_d_nxt      = mem_d;
    way_d_nxt      = way_d;
    way_tag_in_nxt = way_tag_in;
    case (state_nxt)
      S_WB_ADDR: begin
        busy_nxt   = 1'b1;
        way_en_nxt = 1'b1;
        way_a_nxt  = fill_word_nxt & WAY_MASK;
      end
      S_WB_LAT: busy_nxt = 1'b1;
      S_WB_REQ: begin
        busy_nxt   = 1'b1;
        mem_we_nxt = 1'b1;
        mem_a_nxt  = wb_word_nxt;
      end
      S_FILL_REQ: begin
        busy_nxt   = 1'b1;
        mem_rd_nxt = 1'b1;
        mem_a_nxt  = fill_word_nxt;
      end
      S_FILL_WR: begin
        busy_nxt   = 1'b1;
        way_en_nxt = 1'b1;
        way_we_nxt = 1'b1;
        way_a_nxt  = fill_word_nxt & WAY_MASK;
      end
      S_TAG: begin
        busy_nxt       = 1'b1;
        way_en_nxt     = 1'b1;
        way_tag_we_nxt = 1'b1;
        way_a_nxt      = fill_word_nxt & WAY_MASK;
      end
      S_DONE:  done_nxt = 1'b1;
      default: ;
    endcase
    // Way read data lands one cycle after the address, i.e. during WB_LAT
    if (state == S_WB_LAT) mem_d_nxt = way_spo;
    if ((state == S_FILL_REQ) && mem_ready) way_d_nxt = mem_spo;
    if (accept) way_tag_in_nxt = req_tag;
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      way_en     <= 1'b0;
      way_we     <= 1'b0;
      way_tag_we <= 1'b0;
      mem_we     <= 1'b0;
      mem_rd     <= 1'b0;
      way_a      <= '0;
      way_d      <= '0;
      way_tag_in <= '0;
      mem_a      <= '0;
      mem_d      <= '0;
    end else begin
      busy       <= busy_nxt;
      done       <= done_nxt;
      way_en     <= way_en_nxt;
      way_we     <= way_we_nxt;
      way_tag_we <= way_tag_we_nxt;
      mem_we     <= mem_we_nxt;
      mem_rd     <= mem_rd_nxt;
      way_a      <= way_a_nxt;
      way_d      <= way_d_nxt;
      way_tag_in <= way_tag_in_nxt;
      mem_a      <= mem_a_nxt;
      mem_d      <= mem_d_nxt;
    end
  end

endmodule
